// File: rtl/irq_ctrl.sv
// Interrupt controller: a compare/count timer and two synchronized edge-triggered
// lines feed three prioritised exception requests to cp0.

module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  localparam int STAGES = 2;

  logic sync1, sync2, prev;
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  // Suppress edges until the synchronizer has refilled after reset, so a line
  // held high through reset release is not mistaken for a new event.
  assign rise = sync2 & ~prev & vld_pipe[STAGES];
endmodule

module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  irq_in,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        hasexp,
  input  logic        expblock,
  output logic        expsrc0,
  output logic        expsrc1,
  output logic        expsrc2,
  output logic [2:0]  pending,
  output logic [31:0] rdata
);
  localparam int NUM_IRQ = 2;

  logic [31:0]        count, compare;
  logic               en, auto_rl;
  logic [NUM_IRQ-1:0] irq_rise;
  logic               tmatch, cfg_wr;
  logic [2:0]         set_bits, ack_bits, wclr_bits, grant;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in[i]),
      .rise  (irq_rise[i])
    );
  end

  assign cfg_wr = we && (addr == 2'd0 || addr == 2'd1);
  assign tmatch = en && !cfg_wr && (count == compare);

  assign grant[0] = pending[0];
  assign grant[1] = pending[1] & ~pending[0];
  assign grant[2] = pending[2] & ~pending[1] & ~pending[0];

  assign expsrc0 = grant[0] & ~expblock & reset;
  assign expsrc1 = grant[1] & ~expblock & reset;
  assign expsrc2 = grant[2] & ~expblock & reset;

  assign set_bits  = {irq_rise, tmatch};
  assign ack_bits  = hasexp ? {expsrc2, expsrc1, expsrc0} : 3'b000;
  assign wclr_bits = (we && addr == 2'd3) ? wdata[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      compare <= '1;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      pending <= '0;
    end else begin
      if (we && addr == 2'd0) begin
        compare <= wdata;
        count   <= '0;
      end else if (we && addr == 2'd1) begin
        en      <= wdata[0];
        auto_rl <= wdata[1];
        count   <= '0;
      end else if (en) begin
        if (count == compare) begin
          count <= '0;
          if (!auto_rl) en <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end
      // New events win over any clear landing on the same edge.
      pending <= (pending & ~(ack_bits | wclr_bits)) | set_bits;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = compare;
      2'd1:    rdata = {30'd0, auto_rl, en};
      2'd2:    rdata = count;
      default: rdata = {29'd0, pending};
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: timer one-shot/auto-reload, priority, masking,
// set/clear collision and reset mid-operation, with hand-computed expectations.

module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  irq_in;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        hasexp, expblock;
  logic        expsrc0, expsrc1, expsrc2;
  logic [2:0]  pending;
  logic [31:0] rdata;

  int total = 0;
  int passed = 0;
  int failed = 0;

  irq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .hasexp   (hasexp),
    .expblock (expblock),
    .expsrc0  (expsrc0),
    .expsrc1  (expsrc1),
    .expsrc2  (expsrc2),
    .pending  (pending),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic xchk(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, expsrc2, expsrc1, expsrc0}, {29'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic ack();
    hasexp = 1'b1;
    tick();
    hasexp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b0; irq_in = 2'b00; we = 1'b0; addr = 2'd0; wdata = '0;
    hasexp = 1'b0; expblock = 1'b0;
    tick(); tick();

    // Reset values
    rchk("rst_compare", 2'd0, 32'hFFFF_FFFF);
    rchk("rst_control", 2'd1, 32'd0);
    rchk("rst_count",   2'd2, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    xchk("rst_expsrc", 3'b000);
    reset = 1'b1;
    tick(); tick(); tick(); tick();

    // One-shot: COMPARE=5, EN=1 -> match on the 6th counting edge
    wr(2'd0, 32'd5);
    wr(2'd1, 32'd1);
    repeat (5) tick();
    rchk("os_count5", 2'd2, 32'd5);
    chk("os_pend_before", {29'd0, pending}, 32'd0);
    tick();
    chk("os_pend_match", {29'd0, pending}, 32'd1);
    xchk("os_expsrc", 3'b001);
    rchk("os_en_clear", 2'd1, 32'd0);
    rchk("os_count0", 2'd2, 32'd0);
    tick(); tick();
    rchk("os_count_hold", 2'd2, 32'd0);
    ack();
    chk("os_ack", {29'd0, pending}, 32'd0);

    // Auto-reload: COMPARE=2, CONTROL=3 -> match every 3 cycles
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd3);
    tick(); tick();
    chk("ar_pend_pre", {29'd0, pending}, 32'd0);
    tick();
    chk("ar_match1", {29'd0, pending}, 32'd1);
    ack();
    chk("ar_ack", {29'd0, pending}, 32'd0);
    tick();
    chk("ar_pend_mid", {29'd0, pending}, 32'd0);
    tick();
    chk("ar_match2", {29'd0, pending}, 32'd1);
    rchk("ar_en_stays", 2'd1, 32'd3);

    // Collision: ack on the same edge as the next match keeps the bit set
    tick(); tick();
    rchk("col_count2", 2'd2, 32'd2);
    ack();
    chk("col_pend_kept", {29'd0, pending}, 32'd1);
    wr(2'd1, 32'd0);
    chk("col_pend_after_stop", {29'd0, pending}, 32'd1);
    wr(2'd3, 32'd7);
    chk("col_wclr", {29'd0, pending}, 32'd0);
    wr(2'd2, 32'h1234);
    rchk("count_ro", 2'd2, 32'd0);

    // Priority: timer pending, then both lines rise
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    irq_in = 2'b11;
    tick(); tick();
    chk("pr_latency", {29'd0, pending}, 32'b001);
    tick();
    chk("pr_all", {29'd0, pending}, 32'b111);
    xchk("pr_x0", 3'b001);
    ack();
    chk("pr_p1", {29'd0, pending}, 32'b110);
    xchk("pr_x1", 3'b010);
    ack();
    chk("pr_p2", {29'd0, pending}, 32'b100);
    xchk("pr_x2", 3'b100);
    ack();
    chk("pr_p3", {29'd0, pending}, 32'b000);
    xchk("pr_x3", 3'b000);

    // Masking: events accumulate while blocked, ack ignored
    irq_in = 2'b00;
    tick(); tick(); tick();
    irq_in = 2'b01;
    tick(); tick(); tick();
    chk("mk_pend", {29'd0, pending}, 32'b010);
    expblock = 1'b1;
    #1;
    xchk("mk_x_blocked", 3'b000);
    ack();
    chk("mk_ack_ignored", {29'd0, pending}, 32'b010);
    irq_in = 2'b11;
    tick(); tick(); tick();
    chk("mk_accum", {29'd0, pending}, 32'b110);
    xchk("mk_x_still", 3'b000);
    expblock = 1'b0;
    #1;
    xchk("mk_unblock", 3'b010);
    ack();
    chk("mk_ack", {29'd0, pending}, 32'b100);

    // Reset mid-operation with COUNT=0x10 and pending=101
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    tick();
    wr(2'd0, 32'h100);
    wr(2'd1, 32'd1);
    repeat (16) tick();
    rchk("rm_count", 2'd2, 32'h10);
    chk("rm_pend", {29'd0, pending}, 32'b101);
    reset = 1'b0;
    #1;
    xchk("rm_x_during", 3'b000);
    tick();
    reset = 1'b1;
    rchk("rm_count0", 2'd2, 32'd0);
    rchk("rm_compare", 2'd0, 32'hFFFF_FFFF);
    chk("rm_pend0", {29'd0, pending}, 32'd0);
    xchk("rm_x0", 3'b000);
    repeat (6) tick();
    chk("rm_no_edge", {29'd0, pending}, 32'd0);
    rchk("rm_control", 2'd1, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
